// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Shared types and helpers for the APB completer slice.
//   APB_AW / APB_DW : default address / data widths of the APB leg
//   CNT_W           : width of the wait-state counter (0..15 wait states)
//   apb_state_e     : completer FSM states
//   apb_req_s       : request captured at the end of the setup phase
//   access_err()    : out-of-range / write-protect decode
// -----------------------------------------------------------------------------
package apb_pkg;

    localparam int APB_AW = 9;
    localparam int APB_DW = 8;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_e;

    // Sized by the package widths; the completer's AW/DW must match them.
    typedef struct packed {
        logic [APB_AW-1:0] addr;
        logic [APB_DW-1:0] data;
        logic              write;
    } apb_req_s;

    // The full address is compared, so addresses above DEPTH never alias
    // onto implemented locations.
    function automatic logic access_err(
        input logic [APB_AW-1:0] addr,
        input logic              write,
        input int                depth,
        input int                ro_base
    );
        logic [31:0] a;
        a = 32'(addr);
        return (a >= 32'(depth)) || (write && (a >= 32'(ro_base)));
    endfunction

endpackage

// File: rtl/apb_regfile.sv
// -----------------------------------------------------------------------------
// apb_regfile
// DEPTH x DW flop-based storage with asynchronous clear, one synchronous
// write port and one combinational read port.
//   pclk, presetn : clock, async active-low reset (clears every word)
//   we_i          : write enable
//   waddr_i       : write index
//   wdata_i       : write data
//   raddr_i       : read index
//   rdata_o       : read data (combinational from raddr_i)
// -----------------------------------------------------------------------------
module apb_regfile #(
    parameter int DEPTH = 256,
    parameter int DW    = 8,
    parameter int IW    = 8
) (
    input  logic          pclk,
    input  logic          presetn,
    input  logic          we_i,
    input  logic [IW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [IW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    // NOTE: the storage is built from flops rather than a RAM macro precisely
    // so every word can be cleared by the asynchronous reset; a RAM-inferred
    // array must not appear in a reset branch.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            // NOTE: non-blocking assignment for all clocked state, so every
            // flop samples pre-edge values regardless of block ordering.
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/apb_completer_mem.sv
// -----------------------------------------------------------------------------
// apb_completer_mem
// APB3 completer backed by apb_regfile, with WAIT wait states per transfer and
// PSLVERR on out-of-range or write-protected accesses.
//   pclk, presetn : APB clock, async active-low reset
//   psel, penable : select and access-phase strobe from the bridge
//   pwrite        : 1 = write, 0 = read
//   paddr, pwdata : byte address and write data
//   pready        : transfer complete
//   prdata        : read data, non-zero only while pready on a good read
//   pslverr       : error response, only while pready
//
// State naming: the FSM can only see a setup phase at the edge that ends it,
// so SETUP is the first bus access cycle after the request was captured and
// ACCESS covers any further (wait-state) cycles. With WAIT=0 a transfer
// completes straight out of SETUP, giving true zero-wait APB timing.
// All outputs decode registered state only; none depends on the inputs.
// -----------------------------------------------------------------------------
module apb_completer_mem
    import apb_pkg::*;
#(
    parameter int AW      = APB_AW,
    parameter int DW      = APB_DW,
    parameter int DEPTH   = 256,
    parameter int WAIT    = 0,
    parameter int RO_BASE = DEPTH
) (
    input  logic          pclk,
    input  logic          presetn,
    input  logic          psel,
    input  logic          penable,
    input  logic          pwrite,
    input  logic [AW-1:0] paddr,
    input  logic [DW-1:0] pwdata,
    output logic          pready,
    output logic [DW-1:0] prdata,
    output logic          pslverr
);

    localparam int               IW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] WAIT_C = CNT_W'(WAIT);

    apb_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    apb_req_s         req_q;

    logic          in_xfer;
    logic          err;
    logic          we;
    logic [IW-1:0] idx;
    logic [DW-1:0] rdata;

    // ------------------------------------------------------------------------
    // FSM, wait counter and request capture
    // ------------------------------------------------------------------------
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // penable without a preceding setup phase is ignored.
                    if (psel && !penable) begin
                        state_q <= SETUP;
                        cnt_q   <= WAIT_C;
                        req_q   <= '{addr: paddr, data: pwdata, write: pwrite};
                    end
                end
                SETUP, ACCESS: begin
                    if (!psel) begin
                        // Requester walked away: abort, nothing committed.
                        state_q <= IDLE;
                    end else if (penable) begin
                        if (cnt_q == '0) begin
                            // Completion edge; the write commits via we.
                            state_q <= IDLE;
                        end else begin
                            cnt_q   <= cnt_q - 1'b1;
                            state_q <= ACCESS;
                        end
                    end
                    // psel with penable low: hold until the access phase.
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Registered-state decodes
    // ------------------------------------------------------------------------
    assign in_xfer = (state_q != IDLE);
    assign err     = access_err(req_q.addr, req_q.write, DEPTH, RO_BASE);
    assign idx     = req_q.addr[IW-1:0];

    assign pready  = in_xfer && (cnt_q == '0);
    assign pslverr = pready && err;
    assign prdata  = (pready && !req_q.write && !err) ? rdata : '0;

    // Errored writes never reach the storage.
    assign we = pready && psel && penable && req_q.write && !err;

    apb_regfile #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .IW    (IW)
    ) u_regfile (
        .pclk    (pclk),
        .presetn (presetn),
        .we_i    (we),
        .waddr_i (idx),
        .wdata_i (req_q.data),
        .raddr_i (idx),
        .rdata_o (rdata)
    );

endmodule
